// File: rtl/btn_mode_debounce_pkg.sv
// btn_mode_debounce_pkg: shared FSM state encoding and default timing constants for the button front end.
package btn_mode_debounce_pkg;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;
    localparam int STABLE_CYCLES_DEF = 16;
    localparam int LONG_CYCLES_DEF   = 64;
    localparam int CNT_W_DEF         = 8;
endpackage

// File: rtl/btn_mode_debounce_sync_2ff.sv
// sync_2ff: generic two-stage synchronizer for asynchronous single-bit inputs.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic s1_q, s2_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= i_d;
            s2_q <= s1_q;
        end
    end
    assign o_q = s2_q;
endmodule

// File: rtl/btn_mode_debounce.sv
// btn_mode_debounce: synchronize and debounce a push-button, strobe on accepted press and toggle a mode bit.
// Define LONG_PRESS_EN to add a long-press strobe that forces the mode bit back to 0.
module btn_mode_debounce
    import btn_mode_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_btn_level,
    output logic o_press,
    output logic o_mode,
    output logic o_long
);
`ifdef LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_DONE   = CNT_W'(LONG_CYCLES);

    logic s2;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic press_q, press_d, mode_q, mode_d, long_q, long_d, level_q, level_d;

    sync_2ff u_sync (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_d  (i_btn),
        .o_q  (s2)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        long_d  = 1'b0;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (s2) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    mode_d  = ~mode_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                // Count parks one past the threshold so the long strobe fires once per hold
                if (!s2) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (LONG_EN && cnt_q == LONG_LAST) begin
                    cnt_d  = LONG_DONE;
                    long_d = 1'b1;
                    mode_d = 1'b0;
                end else if (LONG_EN && cnt_q < LONG_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            mode_q  <= 1'b0;
            long_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            mode_q  <= mode_d;
            long_q  <= long_d;
            level_q <= level_d;
        end
    end

    assign o_btn_level = level_q;
    assign o_press     = press_q;
    assign o_mode      = mode_q;
    assign o_long      = long_q;
endmodule

// File: tb/tb_btn_mode_debounce.sv
// tb_btn_mode_debounce: directed and random button stimulus checked every cycle against a run-length reference model.
module tb_btn_mode_debounce;
    localparam int S = 4;
    localparam int L = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic o_btn_level, o_press, o_mode, o_long;
    logic armed = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_mode_debounce #(
        .STABLE_CYCLES(S),
        .LONG_CYCLES  (L),
        .CNT_W        (8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn      (btn),
        .o_btn_level(o_btn_level),
        .o_press    (o_press),
        .o_mode     (o_mode),
        .o_long     (o_long)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // Model: the debounced level flips once the synchronized input has disagreed
    // with it for S+1 consecutive edges; a hold of L edges after acceptance is a long press.
    logic m_d1 = 1'b0, m_d2 = 1'b0, m_s;
    logic m_level = 1'b0, m_press = 1'b0, m_long = 1'b0, m_mode = 1'b0;
    int m_run = 0;
    int m_hold = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_d1 = 1'b0; m_d2 = 1'b0;
            m_level = 1'b0; m_press = 1'b0; m_long = 1'b0; m_mode = 1'b0;
            m_run = 0; m_hold = 0;
        end else begin
            m_s = m_d2;
            m_d2 = m_d1;
            m_d1 = btn;
            m_press = 1'b0;
            m_long = 1'b0;
            if (m_s != m_level) begin
                m_run++;
                if (m_run == S + 1) begin
                    m_level = m_s;
                    m_run = 0;
                    m_hold = 0;
                    if (m_s) begin
                        m_press = 1'b1;
                        m_mode = ~m_mode;
                    end
                end
            end else begin
                if (m_level && m_run > 0) m_hold = 0;
                else if (m_level) begin
                    m_hold++;
`ifdef LONG_PRESS_EN
                    if (m_hold == L) begin
                        m_long = 1'b1;
                        m_mode = 1'b0;
                    end
`endif
                end
                m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("level", o_btn_level, m_level);
            chk("press", o_press, m_press);
            chk("mode", o_mode, m_mode);
            chk("long", o_long, m_long);
        end
    end

    task automatic drive(input logic b, input int n);
        btn = b;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset(input logic b, input int n);
        rst = 1'b1;
        drive(b, n);
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        armed = 1'b1;
        #2;
        drive(1'b1, 1);
        rst = 1'b0;
        drive(1'b1, 20);
        drive(1'b0, 20);
        drive(1'b1, 2); drive(1'b0, 2); drive(1'b1, 2); drive(1'b0, 2);
        drive(1'b1, 15);
        drive(1'b0, 15);
        drive(1'b1, 15); drive(1'b0, 2); drive(1'b1, 10);
        drive(1'b0, 15);
        drive(1'b1, 10); drive(1'b0, 10); drive(1'b1, 10);
        drive(1'b0, 15);
        drive(1'b1, 40);
        drive(1'b0, 15);
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, S); drive(1'b0, S + 2);
        drive(1'b1, 8);
        pulse_reset(1'b1, 2);
        drive(1'b1, 15);
        drive(1'b0, 15);
        repeat (400) begin
            if ($urandom_range(0, 39) == 0) pulse_reset(1'($urandom_range(0, 1)), $urandom_range(1, 3));
            else drive(1'($urandom_range(0, 1)), $urandom_range(1, 2 * L + 4));
        end
        drive(1'b0, 20);
        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
